// File: rtl/keypad_code_lock.sv
//==============================================================================
// Module      : keypad_code_lock
// Description : Collects scan-stage key pulses into a fixed-length entry and
//               compares it to CODE. Drives a timed unlock, a fail pulse and a
//               timed lockout. Optional inter-key timeout: KEYPAD_LOCK_TIMEOUT_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module keypad_code_lock #(
    parameter int unsigned             CODE_LEN       = 4,
    parameter logic [2*CODE_LEN-1:0]   CODE           = 8'b10_01_00_10,
    parameter int unsigned             MAX_FAIL       = 3,
    parameter int unsigned             OPEN_CYCLES    = 1000,
    parameter int unsigned             LOCKOUT_CYCLES = 5000,
    parameter int unsigned             TIMEOUT_CYCLES = 10000
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [2:0]                      key_pulse,
    input  logic                            clear,
    output logic                            unlocked,
    output logic                            fail,
    output logic                            locked_out,
    output logic [$clog2(CODE_LEN+1)-1:0]   entry_count,
    output logic                            timeout
);

    localparam int unsigned CNT_W  = $clog2(CODE_LEN + 1);
    localparam int unsigned FAIL_W = $clog2(MAX_FAIL + 1);
    localparam int unsigned OL_MAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
`ifdef KEYPAD_LOCK_TIMEOUT_EN
    localparam int unsigned CYC_MAX = (TIMEOUT_CYCLES > OL_MAX) ? TIMEOUT_CYCLES : OL_MAX;
`else
    localparam int unsigned CYC_MAX = OL_MAX;
`endif
    localparam int unsigned CYC_W  = $clog2(CYC_MAX + 1);

    localparam logic [CYC_W-1:0]  C_OPEN_LAST = CYC_W'(OPEN_CYCLES - 1);
    localparam logic [CYC_W-1:0]  C_LOCK_LAST = CYC_W'(LOCKOUT_CYCLES - 1);
`ifdef KEYPAD_LOCK_TIMEOUT_EN
    localparam logic [CYC_W-1:0]  C_TMO_LAST  = CYC_W'(TIMEOUT_CYCLES - 1);
`endif
    localparam logic [CNT_W-1:0]  C_LAST_IDX  = CNT_W'(CODE_LEN - 1);
    localparam logic [FAIL_W-1:0] C_FAIL_LIM  = FAIL_W'(MAX_FAIL);

    if (CODE_LEN < 1 || CODE_LEN > 8 || MAX_FAIL < 1 || OPEN_CYCLES < 1 ||
        LOCKOUT_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("keypad_code_lock: illegal parameter value");
    end

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENTRY   = 3'd1,
        S_CHECK   = 3'd2,
        S_OPEN    = 3'd3,
        S_LOCKOUT = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [2*CODE_LEN-1:0]   buf_q, buf_d;
    logic                    inv_q, inv_d;
    logic [FAIL_W-1:0]       fail_cnt_q, fail_cnt_d;
    logic [CYC_W-1:0]        cyc_q, cyc_d;
    logic                    unlocked_q, unlocked_d;
    logic                    fail_q, fail_d;
    logic                    locked_out_q, locked_out_d;
    logic                    timeout_q, timeout_d;

    logic                    w_press;
    logic [1:0]              w_sym;
    logic                    w_sym_bad;
    logic [FAIL_W-1:0]       w_fail_inc;

    // clear takes priority over a simultaneous press in every state
    always_comb begin
        w_press   = (key_pulse != 3'b000) && !clear;
        w_sym     = 2'd0;
        w_sym_bad = 1'b0;
        case (key_pulse)
            3'b001:  w_sym = 2'd0;
            3'b010:  w_sym = 2'd1;
            3'b100:  w_sym = 2'd2;
            default: w_sym_bad = 1'b1;
        endcase
    end

    assign w_fail_inc = fail_cnt_q + FAIL_W'(1);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        buf_d      = buf_q;
        inv_d      = inv_q;
        fail_cnt_d = fail_cnt_q;
        cyc_d      = cyc_q;
        fail_d     = 1'b0;
        timeout_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (w_press) begin
                    buf_d[1:0] = w_sym;
                    inv_d      = w_sym_bad;
                    cnt_d      = CNT_W'(1);
                    cyc_d      = '0;
                    state_d    = (CODE_LEN == 1) ? S_CHECK : S_ENTRY;
                end
            end
            S_ENTRY: begin
                if (clear) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    inv_d   = 1'b0;
                end else if (w_press) begin
                    for (int i = 0; i < CODE_LEN; i++) begin
                        if (cnt_q == CNT_W'(i)) buf_d[2*i +: 2] = w_sym;
                    end
                    inv_d = inv_q | w_sym_bad;
                    cnt_d = cnt_q + CNT_W'(1);
                    cyc_d = '0;
                    if (cnt_q == C_LAST_IDX) state_d = S_CHECK;
`ifdef KEYPAD_LOCK_TIMEOUT_EN
                end else if (cyc_q == C_TMO_LAST) begin
                    state_d   = S_IDLE;
                    cnt_d     = '0;
                    inv_d     = 1'b0;
                    timeout_d = 1'b1;
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
`endif
                end
            end
            S_CHECK: begin
                cnt_d = '0;
                inv_d = 1'b0;
                cyc_d = '0;
                if ((buf_q == CODE) && !inv_q) begin
                    state_d    = S_OPEN;
                    fail_cnt_d = '0;
                end else begin
                    fail_d     = 1'b1;
                    fail_cnt_d = w_fail_inc;
                    state_d    = (w_fail_inc == C_FAIL_LIM) ? S_LOCKOUT : S_IDLE;
                end
            end
            S_OPEN: begin
                if (clear || (cyc_q == C_OPEN_LAST)) begin
                    state_d = S_IDLE;
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            S_LOCKOUT: begin
                if (cyc_q == C_LOCK_LAST) begin
                    state_d    = S_IDLE;
                    fail_cnt_d = '0;
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                inv_d   = 1'b0;
            end
        endcase

        // level outputs follow the next state so they are registered with it
        unlocked_d   = (state_d == S_OPEN);
        locked_out_d = (state_d == S_LOCKOUT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            buf_q        <= '0;
            inv_q        <= 1'b0;
            fail_cnt_q   <= '0;
            cyc_q        <= '0;
            unlocked_q   <= 1'b0;
            fail_q       <= 1'b0;
            locked_out_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            buf_q        <= buf_d;
            inv_q        <= inv_d;
            fail_cnt_q   <= fail_cnt_d;
            cyc_q        <= cyc_d;
            unlocked_q   <= unlocked_d;
            fail_q       <= fail_d;
            locked_out_q <= locked_out_d;
            timeout_q    <= timeout_d;
        end
    end

    assign unlocked    = unlocked_q;
    assign fail        = fail_q;
    assign locked_out  = locked_out_q;
    assign entry_count = cnt_q;
    assign timeout     = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_keypad_code_lock.sv
//==============================================================================
// Module      : tb_keypad_code_lock
// Description : Scoreboard bench for keypad_code_lock: output events are queued
//               at stimulus time and matched by a negedge monitor.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_keypad_code_lock;

    localparam int CODE_LEN       = 4;
    localparam int MAX_FAIL       = 3;
    localparam int OPEN_CYCLES    = 1000;
    localparam int LOCKOUT_CYCLES = 5000;
    localparam int TIMEOUT_CYCLES = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] key_pulse = 3'b000;
    logic       clear = 1'b0;
    logic       unlocked, fail, locked_out, timeout;
    logic [2:0] entry_count;

    keypad_code_lock #(
        .CODE_LEN       (CODE_LEN),
        .CODE           (8'b10_01_00_10),
        .MAX_FAIL       (MAX_FAIL),
        .OPEN_CYCLES    (OPEN_CYCLES),
        .LOCKOUT_CYCLES (LOCKOUT_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_pulse   (key_pulse),
        .clear       (clear),
        .unlocked    (unlocked),
        .fail        (fail),
        .locked_out  (locked_out),
        .entry_count (entry_count),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum int {EV_FAIL, EV_TIMEOUT, EV_UNL_RISE, EV_UNL_FALL, EV_LOCK_RISE, EV_LOCK_FALL} ev_t;
    typedef struct {
        ev_t kind;
        int  at;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   last_edge = 0;
    logic unl_prev = 1'b0;
    logic lock_prev = 1'b0;

    task automatic expect_ev(input ev_t k, input int at);
        exp_t e;
        e.kind = k;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    task automatic observe(input ev_t k);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event got %s at cycle %0d expected none", k.name(), cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.at != cyc) begin
                errors++;
                $display("FAIL event got %s@%0d expected %s@%0d", k.name(), cyc, e.kind.name(), e.at);
            end
        end
    endtask

    always @(negedge clk) begin
        if (fail)                    observe(EV_FAIL);
        if (timeout)                 observe(EV_TIMEOUT);
        if (unlocked && !unl_prev)   observe(EV_UNL_RISE);
        if (!unlocked && unl_prev)   observe(EV_UNL_FALL);
        if (locked_out && !lock_prev) observe(EV_LOCK_RISE);
        if (!locked_out && lock_prev) observe(EV_LOCK_FALL);
        unl_prev  = unlocked;
        lock_prev = locked_out;
    end

    task automatic check(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, act, expv);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic [2:0] k);
        key_pulse = k;
        @(posedge clk);
        #1 key_pulse = 3'b000;
        last_edge = cyc;
    endtask

    // four presses separated by three idle cycles; returns right after the last one
    task automatic entry4(input logic [2:0] a, input logic [2:0] b,
                          input logic [2:0] c, input logic [2:0] d);
        press(a); check("entry_count_1", int'(entry_count), 1); idle(3);
        press(b); check("entry_count_2", int'(entry_count), 2); idle(3);
        press(c); check("entry_count_3", int'(entry_count), 3); idle(3);
        press(d); check("entry_count_4", int'(entry_count), 4);
    endtask

    task automatic good_entry_and_open();
        entry4(3'b100, 3'b001, 3'b010, 3'b100);
        expect_ev(EV_UNL_RISE, last_edge + 1);
        expect_ev(EV_UNL_FALL, last_edge + 1 + OPEN_CYCLES);
        idle(OPEN_CYCLES + 10);
        check("unlocked_after_open", int'(unlocked), 0);
    endtask

    task automatic wrong_entry();
        entry4(3'b100, 3'b001, 3'b010, 3'b001);
        expect_ev(EV_FAIL, last_edge + 1);
    endtask

    initial begin
        #2;
        check("reset_unlocked", int'(unlocked), 0);
        check("reset_fail", int'(fail), 0);
        check("reset_locked_out", int'(locked_out), 0);
        check("reset_timeout", int'(timeout), 0);
        check("reset_entry_count", int'(entry_count), 0);
        @(posedge clk);
        #1 rst = 1'b1;
        idle(2);

        // correct code opens for OPEN_CYCLES
        good_entry_and_open();

        // one wrong entry, then a correct one
        wrong_entry();
        idle(1);
        check("count_after_fail", int'(entry_count), 0);
        check("unlocked_after_fail", int'(unlocked), 0);
        idle(2);
        good_entry_and_open();

        // three wrong entries lock out; presses ignored meanwhile
        wrong_entry(); idle(3);
        wrong_entry(); idle(3);
        entry4(3'b100, 3'b001, 3'b010, 3'b001);
        expect_ev(EV_FAIL, last_edge + 1);
        expect_ev(EV_LOCK_RISE, last_edge + 1);
        expect_ev(EV_LOCK_FALL, last_edge + 1 + LOCKOUT_CYCLES);
        idle(1);
        check("locked_out_high", int'(locked_out), 1);
        press(3'b100);
        check("count_in_lockout_a", int'(entry_count), 0);
        idle(10);
        press(3'b001);
        check("count_in_lockout_b", int'(entry_count), 0);
        idle(LOCKOUT_CYCLES);
        check("locked_out_low", int'(locked_out), 0);
        good_entry_and_open();

        // invalid symbol fails and counts toward lockout
        entry4(3'b100, 3'b011, 3'b010, 3'b100);
        expect_ev(EV_FAIL, last_edge + 1);
        idle(3);
        wrong_entry(); idle(3);
        entry4(3'b100, 3'b001, 3'b010, 3'b001);
        expect_ev(EV_FAIL, last_edge + 1);
        expect_ev(EV_LOCK_RISE, last_edge + 1);
        expect_ev(EV_LOCK_FALL, last_edge + 1 + LOCKOUT_CYCLES);
        idle(LOCKOUT_CYCLES + 10);

        // clear mid-entry, clear with press in IDLE and in ENTRY
        press(3'b100); idle(3);
        press(3'b001);
        check("count_before_clear", int'(entry_count), 2);
        idle(2);
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        check("count_after_clear", int'(entry_count), 0);
        idle(3);
        clear = 1'b1;
        press(3'b100);
        clear = 1'b0;
        check("clear_press_idle", int'(entry_count), 0);
        press(3'b100);
        check("count_one", int'(entry_count), 1);
        idle(2);
        clear = 1'b1;
        press(3'b001);
        clear = 1'b0;
        check("clear_press_entry", int'(entry_count), 0);
        idle(3);

        // clear during OPEN drops unlocked the following cycle
        entry4(3'b100, 3'b001, 3'b010, 3'b100);
        expect_ev(EV_UNL_RISE, last_edge + 1);
        expect_ev(EV_UNL_FALL, last_edge + 2);
        @(posedge clk);
        #1 clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        check("unlocked_after_clear", int'(unlocked), 0);
        idle(3);

        // async reset mid-entry also clears the fail counter
        wrong_entry(); idle(3);
        press(3'b100);
        idle(1);
        check("count_before_rst", int'(entry_count), 1);
        rst = 1'b0;
        #1;
        check("rst_entry_count", int'(entry_count), 0);
        check("rst_unlocked", int'(unlocked), 0);
        check("rst_fail", int'(fail), 0);
        check("rst_locked_out", int'(locked_out), 0);
        check("rst_timeout", int'(timeout), 0);
        @(posedge clk);
        #1 rst = 1'b1;
        idle(2);
        wrong_entry(); idle(3);
        wrong_entry(); idle(3);
        check("no_lockout_after_rst", int'(locked_out), 0);

`ifdef KEYPAD_LOCK_TIMEOUT_EN
        press(3'b100);
        expect_ev(EV_TIMEOUT, last_edge + TIMEOUT_CYCLES);
        idle(TIMEOUT_CYCLES);
        check("count_after_timeout", int'(entry_count), 0);
        idle(3);
`endif

        idle(5);
        check("pending_events", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
